// File: rtl/reg_share_arbiter_if.sv
// Bus between the producers and the shared-register arbiter.
// Producers drive the request/data side; the arbiter returns ownership and the register value.
interface reg_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         q;
    logic [DATA_W-1:0]         q_not;
    logic                      q_valid;
    logic [OWN_W-1:0]          owner;

    modport master (
        output req, wdata,
        input  grant, ack, q, q_not, q_valid, owner
    );

    modport slave (
        input  req, wdata,
        output grant, ack, q, q_not, q_valid, owner
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter owning one shared data register; each winner loads it once
// and keeps it frozen for up to HOLD_CYC cycles or until it drops its request.
module reg_share_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = 2
) (
    input  logic               clk,
    input  logic               reset,
    reg_share_arbiter_if.slave bus
);
    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state, state_nxt;
    logic [OWN_W-1:0]   ptr, ptr_nxt;
    logic [OWN_W-1:0]   owner_r, owner_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_REQ-1:0] grant_r, grant_nxt;
    logic [NUM_REQ-1:0] ack_r, ack_nxt;
    logic [DATA_W-1:0]  q_r, q_nxt;
    logic               q_valid_r, q_valid_nxt;

    logic [OWN_W-1:0]   owner_inc;
    logic [OWN_W-1:0]   arb_base;
    logic [OWN_W-1:0]   arb_idx;
    logic [OWN_W-1:0]   cand;
    logic               arb_found;
    logic               release_now;

    // While owning, the scan already starts after the owner so a release can hand off in the same edge.
    assign owner_inc   = (owner_r == LAST_IDX) ? '0 : owner_r + 1'b1;
    assign arb_base    = (state == OWN) ? owner_inc : ptr;
    assign release_now = (cnt == '0) || !bus.req[owner_r];

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(arb_base) + k >= NUM_REQ) ? OWN_W'(int'(arb_base) + k - NUM_REQ)
                                                   : OWN_W'(int'(arb_base) + k);
            if (!arb_found && bus.req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner_r   <= '0;
            cnt       <= '0;
            grant_r   <= '0;
            ack_r     <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner_r   <= owner_nxt;
            cnt       <= cnt_nxt;
            grant_r   <= grant_nxt;
            ack_r     <= ack_nxt;
            q_r       <= q_nxt;
            q_valid_r <= q_valid_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        owner_nxt   = owner_r;
        cnt_nxt     = cnt;
        grant_nxt   = grant_r;
        ack_nxt     = '0;
        q_nxt       = q_r;
        q_valid_nxt = q_valid_r;

        if (state == OWN && !release_now) begin
            cnt_nxt = cnt - 1'b1;
        end else begin
            if (state == OWN) begin
                ptr_nxt = owner_inc;
            end
            if (arb_found) begin
                state_nxt          = OWN;
                grant_nxt          = '0;
                grant_nxt[arb_idx] = 1'b1;
                ack_nxt            = '0;
                ack_nxt[arb_idx]   = 1'b1;
                q_nxt              = bus.wdata[arb_idx*DATA_W +: DATA_W];
                q_valid_nxt        = 1'b1;
                owner_nxt          = arb_idx;
                cnt_nxt            = CNT_LOAD;
            end else begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        end
    end

    always_comb begin
        bus.grant   = grant_r;
        bus.ack     = ack_r;
        bus.q       = q_r;
        bus.q_not   = ~q_r;
        bus.q_valid = q_valid_r;
        bus.owner   = owner_r;
    end
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: one vector per clock edge, inputs applied
// before the edge and outputs compared on the following falling edge.
module tb_reg_share_arbiter;
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  grant;
        logic [3:0]  ack;
        logic [7:0]  q;
        logic        q_valid;
        logic [1:0]  owner;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];

    reg_share_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    reg_share_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYC(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic rst, input logic [3:0] req, input logic [31:0] wdata,
                                   input logic [3:0] grant, input logic [3:0] ack, input logic [7:0] q,
                                   input logic q_valid, input logic [1:0] owner);
        vec_t v;
        v.rst = rst; v.req = req; v.wdata = wdata;
        v.grant = grant; v.ack = ack; v.q = q; v.q_valid = q_valid; v.owner = owner;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset     = v.rst;
        bus.req   = v.req;
        bus.wdata = v.wdata;
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        logic [7:0] exp_not;
        exp_not = ~v.q;
        checks++;
        if (bus.grant !== v.grant || bus.ack !== v.ack || bus.q !== v.q || bus.q_not !== exp_not ||
            bus.q_valid !== v.q_valid || bus.owner !== v.owner) begin
            failures++;
            $display("[TB] FAIL %s: got grant=%b ack=%b q=%h q_not=%h q_valid=%b owner=%0d, want grant=%b ack=%b q=%h q_not=%h q_valid=%b owner=%0d",
                     name, bus.grant, bus.ack, bus.q, bus.q_not, bus.q_valid, bus.owner,
                     v.grant, v.ack, v.q, exp_not, v.q_valid, v.owner);
        end
    endtask

    task automatic runVec(input vec_t v, input string name);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, name);
    endtask

    initial begin
        int   waited;
        logic got;

        // Reset held with every requester active.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkVec(1, 4'b1111, 32'h5C5C5C5C, 4'b0000, 4'b0000, 8'h00, 0, 2'd0));
        // Single request, dropped right after the ack.
        vecs.push_back(mkVec(0, 4'b0100, 32'h00A50000, 4'b0100, 4'b0100, 8'hA5, 1, 2'd2));
        vecs.push_back(mkVec(0, 4'b0000, 32'h00A50000, 4'b0000, 4'b0000, 8'hA5, 1, 2'd2));
        vecs.push_back(mkVec(0, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'hA5, 1, 2'd2));
        // Re-centre the pointer, then a full rotation with all requesters held.
        vecs.push_back(mkVec(1, 4'b1111, 32'h13121110, 4'b0000, 4'b0000, 8'h00, 0, 2'd0));
        vecs.push_back(mkVec(0, 4'b1111, 32'h13121110, 4'b0001, 4'b0001, 8'h10, 1, 2'd0));
        vecs.push_back(mkVec(0, 4'b1111, 32'h13121110, 4'b0001, 4'b0000, 8'h10, 1, 2'd0));
        vecs.push_back(mkVec(0, 4'b1111, 32'h13121110, 4'b0010, 4'b0010, 8'h11, 1, 2'd1));
        vecs.push_back(mkVec(0, 4'b1111, 32'h13121110, 4'b0010, 4'b0000, 8'h11, 1, 2'd1));
        vecs.push_back(mkVec(0, 4'b1111, 32'h13121110, 4'b0100, 4'b0100, 8'h12, 1, 2'd2));
        vecs.push_back(mkVec(0, 4'b1111, 32'h13121110, 4'b0100, 4'b0000, 8'h12, 1, 2'd2));
        vecs.push_back(mkVec(0, 4'b1111, 32'h13121110, 4'b1000, 4'b1000, 8'h13, 1, 2'd3));
        vecs.push_back(mkVec(0, 4'b1111, 32'h13121110, 4'b1000, 4'b0000, 8'h13, 1, 2'd3));
        vecs.push_back(mkVec(0, 4'b1111, 32'h13121110, 4'b0001, 4'b0001, 8'h10, 1, 2'd0));
        vecs.push_back(mkVec(0, 4'b1111, 32'h13121110, 4'b0001, 4'b0000, 8'h10, 1, 2'd0));
        // Handoff to 1, then early drop by 1 while 3 is waiting.
        vecs.push_back(mkVec(0, 4'b0010, 32'h3C002200, 4'b0010, 4'b0010, 8'h22, 1, 2'd1));
        vecs.push_back(mkVec(0, 4'b1000, 32'h3C002200, 4'b1000, 4'b1000, 8'h3C, 1, 2'd3));
        vecs.push_back(mkVec(0, 4'b0000, 32'h3C002200, 4'b0000, 4'b0000, 8'h3C, 1, 2'd3));

        reset     = 1'b1;
        bus.req   = '0;
        bus.wdata = '0;

        foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

        // Sole requester is re-granted at its own release edge and captures fresh data.
        runVec(mkVec(1, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'h00, 0, 2'd0), "sole_reset");
        runVec(mkVec(0, 4'b0001, 32'h00000001, 4'b0001, 4'b0001, 8'h01, 1, 2'd0), "sole_grant1");
        runVec(mkVec(0, 4'b0001, 32'h00000002, 4'b0001, 4'b0000, 8'h01, 1, 2'd0), "sole_hold1");
        runVec(mkVec(0, 4'b0001, 32'h00000002, 4'b0001, 4'b0001, 8'h02, 1, 2'd0), "sole_grant2");
        runVec(mkVec(0, 4'b0001, 32'h00000002, 4'b0001, 4'b0000, 8'h02, 1, 2'd0), "sole_hold2");

        // Reset while requester 1 owns the register.
        runVec(mkVec(1, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'h00, 0, 2'd0), "mid_pre");
        runVec(mkVec(0, 4'b0010, 32'h00007700, 4'b0010, 4'b0010, 8'h77, 1, 2'd1), "mid_own");
        runVec(mkVec(1, 4'b0010, 32'h00007700, 4'b0000, 4'b0000, 8'h00, 0, 2'd0), "mid_reset");
        runVec(mkVec(0, 4'b0010, 32'h00007700, 4'b0010, 4'b0010, 8'h77, 1, 2'd1), "mid_regrant");

        // Requester 3 behind three busy peers must be acked within the round-robin bound.
        runVec(mkVec(1, 4'b0000, 32'h00000000, 4'b0000, 4'b0000, 8'h00, 0, 2'd0), "wait_reset");
        reset     = 1'b0;
        bus.req   = 4'b1111;
        bus.wdata = 32'h44332211;
        waited    = 0;
        got       = 1'b0;
        while (!got && waited < 12) begin
            @(negedge clk);
            waited++;
            if (bus.ack[3]) got = 1'b1;
        end
        checks++;
        if (!got || waited != 7) begin
            failures++;
            $display("[TB] FAIL wait_req3: got acked=%b after %0d edges, want acked=1 after 7 edges", got, waited);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
